// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the RV32I core. Owns the program counter, drives
//   the synchronous-read instruction memory and hands a registered
//   instruction/PC pair to decode. A one-entry skid buffer absorbs the word that
//   is already in flight when decode stalls; taken branches from execute
//   redirect the PC and squash any wrong-path word.
//
// Ports
//   clk          core clock, all state changes on posedge
//   rst_n        synchronous active-low reset
//   Stall        decode cannot accept a new instruction this edge
//   BranchTaken  execute redirects fetch this edge
//   BranchTarget redirect address (bits [1:0] ignored)
//   Address      fetch address to instruction memory (the PC)
//   Word         memory data for the Address sampled at the previous edge
//   InstrOut     instruction to decode
//   PcOut        PC of InstrOut
//   InstrValid   InstrOut/PcOut hold a real, non-squashed instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] Address,
    input  logic [31:0] Word,
    output logic [31:0] InstrOut,
    output logic [31:0] PcOut,
    output logic        InstrValid
);

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // Program counter and in-flight request tag
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] req_pc_q,    req_pc_d;
    logic            req_valid_q, req_valid_d;

    // Skid entry holding the word that arrived while decode was stalled
    logic [XLEN-1:0] skid_word_q,  skid_word_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic            skid_valid_q, skid_valid_d;

    // IF/ID output register
    logic [XLEN-1:0] instr_q,       instr_d;
    logic [XLEN-1:0] pc_out_q,      pc_out_d;
    logic            instr_valid_q, instr_valid_d;

    logic [XLEN-1:0] target_aligned_c;
    logic [XLEN-1:0] pc_inc_c;
    logic            unused_tgt_bits;

    // Redirect targets are always word aligned; the low bits carry no meaning.
    assign target_aligned_c = {BranchTarget[XLEN-1:2], 2'b00};
    assign unused_tgt_bits  = ^BranchTarget[1:0];
    assign pc_inc_c         = pc_q + XLEN'(INSTR_BYTES);

    // Next-state: redirect beats stall beats advance
    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_valid_d   = req_valid_q;
        skid_word_d   = skid_word_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;

        if (BranchTaken) begin
            // Squash everything in flight; outputs keep their stale payload.
            pc_d          = target_aligned_c;
            req_valid_d   = 1'b0;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
        end else if (Stall) begin
            // PC holds, so no new request; park the arriving word if any.
            req_valid_d = 1'b0;
            if (req_valid_q && !skid_valid_q) begin
                skid_word_d  = Word;
                skid_pc_d    = req_pc_q;
                skid_valid_d = 1'b1;
            end
        end else begin
            // The skid entry is older than anything in flight, so it goes first.
            if (skid_valid_q) begin
                instr_d       = skid_word_q;
                pc_out_d      = skid_pc_q;
                instr_valid_d = 1'b1;
                skid_valid_d  = 1'b0;
            end else begin
                instr_d       = Word;
                pc_out_d      = req_pc_q;
                instr_valid_d = req_valid_q;
            end
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_inc_c;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            req_valid_q   <= 1'b0;
            skid_word_q   <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            skid_word_q   <= skid_word_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // A parked word means the PC was held, so no request can be outstanding.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(skid_valid_q && req_valid_q));
        end
    end

    assign Address    = pc_q;
    assign InstrOut   = instr_q;
    assign PcOut      = pc_out_q;
    assign InstrValid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: a directed vector table, hand-written
//   corner sequences, then randomized traffic checked against a queue-based
//   model of the instruction stream.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] Address;
    logic [31:0] Word = 32'h0;
    logic [31:0] InstrOut;
    logic [31:0] PcOut;
    logic        InstrValid;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.RESET_PC(32'h0000_0004)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Address      (Address),
        .Word         (Word),
        .InstrOut     (InstrOut),
        .PcOut        (PcOut),
        .InstrValid   (InstrValid)
    );

    always #5 clk = ~clk;

    // Program image: the standard program plus a deterministic filler pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd4:   mem_word = 32'h0010_0093;
            32'd8:   mem_word = 32'h0020_0113;
            32'd12:  mem_word = 32'h0000_0033;
            32'd16:  mem_word = 32'h0000_0000;
            32'd44:  mem_word = 32'h01F2_F313;
            default: mem_word = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Synchronous-read memory: one edge of latency.
    always @(posedge clk) Word <= mem_word(Address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst_n = r; Stall = s; BranchTaken = b; BranchTarget = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] addr, input logic v,
                             input logic chk, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".addr"}, Address, addr);
        check({tag, ".valid"}, 32'(InstrValid), 32'(v));
        if (chk) begin
            check({tag, ".pc"}, PcOut, pc);
            check({tag, ".instr"}, InstrOut, ins);
        end
    endtask

    // Directed vector table
    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        chk_out;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic s, input logic b, input logic [31:0] t,
                           input logic [31:0] a, input logic v, input logic c,
                           input logic [31:0] p, input logic [31:0] i);
        vec_t e;
        e.rst_n = r; e.stall = s; e.br = b; e.tgt = t;
        e.exp_addr = a; e.exp_valid = v; e.chk_out = c; e.exp_pc = p; e.exp_instr = i;
        vecs.push_back(e);
    endtask

    // Reference model: the fetch stream as a queue of fetched, undelivered PCs.
    logic [31:0] m_pc;
    logic [31:0] m_pending[$];
    logic        m_valid;
    logic        m_known;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic [31:0] p;
        if (!r) begin
            m_pc = 32'h4;
            m_pending.delete();
            m_valid = 1'b0; m_known = 1'b1;
            m_out_pc = 32'h0; m_out_instr = 32'h0;
        end else if (b) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_pending.delete();
            m_valid = 1'b0;
        end else if (!s) begin
            if (m_pending.size() > 0) begin
                p = m_pending.pop_front();
                m_valid = 1'b1; m_known = 1'b1;
                m_out_pc = p; m_out_instr = mem_word(p);
            end else begin
                m_valid = 1'b0; m_known = 1'b0;
            end
            m_pending.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        // Reset, free-run, stall, branch and wrap
        add_vec(0,0,0,0,           32'd4,  0,1, 32'd0,  32'h0);
        add_vec(0,0,0,0,           32'd4,  0,1, 32'd0,  32'h0);
        add_vec(1,0,0,0,           32'd8,  0,0, 32'd0,  32'h0);
        add_vec(1,0,0,0,           32'd12, 1,1, 32'd4,  32'h0010_0093);
        add_vec(1,0,0,0,           32'd16, 1,1, 32'd8,  32'h0020_0113);
        add_vec(1,1,0,0,           32'd16, 1,1, 32'd8,  32'h0020_0113);
        add_vec(1,1,0,0,           32'd16, 1,1, 32'd8,  32'h0020_0113);
        add_vec(1,1,0,0,           32'd16, 1,1, 32'd8,  32'h0020_0113);
        add_vec(1,0,0,0,           32'd20, 1,1, 32'd12, 32'h0000_0033);
        add_vec(1,0,0,0,           32'd24, 1,1, 32'd16, 32'h0000_0000);
        add_vec(1,0,0,0,           32'd28, 1,1, 32'd20, mem_word(32'd20));
        add_vec(1,0,1,32'd44,      32'd44, 0,1, 32'd20, mem_word(32'd20));
        add_vec(1,0,0,0,           32'd48, 0,0, 32'd0,  32'h0);
        add_vec(1,0,0,0,           32'd52, 1,1, 32'd44, 32'h01F2_F313);
        add_vec(1,0,0,0,           32'd56, 1,1, 32'd48, mem_word(32'd48));
        add_vec(1,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,1, 32'd48, mem_word(32'd48));
        add_vec(1,0,0,0,           32'd0,  0,0, 32'd0,  32'h0);
        add_vec(1,0,0,0,           32'd4,  1,1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        add_vec(1,0,0,0,           32'd8,  1,1, 32'd0,  mem_word(32'd0));

        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            check_out($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_valid,
                      vecs[i].chk_out, vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Redirect together with stall while the skid entry is full
        drive_edge(1,1,0,0);          check_out("bs_fill",  32'd8,  1,1, 32'd0,  mem_word(32'd0));
        drive_edge(1,1,1,32'd53);     check_out("bs_redir", 32'd52, 0,1, 32'd0,  mem_word(32'd0));
        drive_edge(1,0,0,0);          check_out("bs_b1",    32'd56, 0,0, 32'd0,  32'h0);
        drive_edge(1,0,0,0);          check_out("bs_b2",    32'd60, 1,1, 32'd52, mem_word(32'd52));

        // Back-to-back redirects: only the last target is presented
        drive_edge(1,0,1,32'd100);    check_out("bb_r1",    32'd100, 0,1, 32'd52, mem_word(32'd52));
        drive_edge(1,0,1,32'd200);    check_out("bb_r2",    32'd200, 0,1, 32'd52, mem_word(32'd52));
        drive_edge(1,0,0,0);          check_out("bb_b1",    32'd204, 0,0, 32'd0,  32'h0);
        drive_edge(1,0,0,0);          check_out("bb_b2",    32'd208, 1,1, 32'd200, mem_word(32'd200));

        // Reset in the middle of a stall with the skid full
        drive_edge(1,1,0,0);          check_out("rs_fill",  32'd208, 1,1, 32'd200, mem_word(32'd200));
        drive_edge(0,1,0,0);          check_out("rs_rst",   32'd4,   0,1, 32'd0,   32'h0);
        drive_edge(1,0,0,0);          check_out("rs_s1",    32'd8,   0,0, 32'd0,   32'h0);
        drive_edge(1,0,0,0);          check_out("rs_s2",    32'd12,  1,1, 32'd4,   32'h0010_0093);
        drive_edge(1,0,0,0);          check_out("rs_s3",    32'd16,  1,1, 32'd8,   32'h0020_0113);

        // Randomized traffic against the model
        for (int k = 0; k < 2; k++) begin
            model_step(0, 0, 0, 0);
            drive_edge(0, 0, 0, 0);
        end
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) < 1);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
            model_step(r, s, b, t);
            drive_edge(r, s, b, t);
            check("rnd.addr", Address, m_pc);
            check("rnd.valid", 32'(InstrValid), 32'(m_valid));
            if (m_known) begin
                check("rnd.pc", PcOut, m_out_pc);
                check("rnd.instr", InstrOut, m_out_instr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
